// File: rtl/wb_regfile_bypass.sv
// wb_regfile_bypass: write-back register file with same-cycle write-to-read bypass,
// per-register written-since-reset tracking and a saturating write counter.
module wb_regfile_bypass #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read1RegSel,
    input  logic [ADDR_W-1:0] read2RegSel,
    input  logic [ADDR_W-1:0] writeRegSel,
    input  logic [WIDTH-1:0]  writeData,
    input  logic              writeEn,
    output logic [WIDTH-1:0]  read1Data,
    output logic [WIDTH-1:0]  read2Data,
    output logic              read1Uninit,
    output logic              read2Uninit,
    output logic [15:0]       wrCount
);
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] written;
    logic                byp1;
    logic                byp2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            written <= '0;
            wrCount <= '0;
        end else if (writeEn) begin
            regs[writeRegSel]    <= writeData;
            written[writeRegSel] <= 1'b1;
            wrCount              <= wrCount + {15'd0, wrCount != 16'hFFFF};
        end
    end

    // Bypass is gated by rst_n so reset forces 0/uninit even with writeEn high
    always_comb begin
        byp1        = rst_n && writeEn && (writeRegSel == read1RegSel);
        byp2        = rst_n && writeEn && (writeRegSel == read2RegSel);
        read1Data   = !rst_n ? '0 : byp1 ? writeData : regs[read1RegSel];
        read2Data   = !rst_n ? '0 : byp2 ? writeData : regs[read2RegSel];
        read1Uninit = !rst_n || (!byp1 && !written[read1RegSel]);
        read2Uninit = !rst_n || (!byp2 && !written[read2RegSel]);
    end
endmodule

// File: tb/tb_wb_regfile_bypass.sv
// tb_wb_regfile_bypass: directed vectors with expected responses queued to a negedge monitor.
module tb_wb_regfile_bypass;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  read1RegSel = '0;
    logic [2:0]  read2RegSel = '0;
    logic [2:0]  writeRegSel = '0;
    logic [15:0] writeData = '0;
    logic        writeEn = 1'b0;
    logic [15:0] read1Data;
    logic [15:0] read2Data;
    logic        read1Uninit;
    logic        read2Uninit;
    logic [15:0] wrCount;

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        u1;
        logic        u2;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    wb_regfile_bypass #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
        .read1Data(read1Data), .read2Data(read2Data),
        .read1Uninit(read1Uninit), .read2Uninit(read2Uninit),
        .wrCount(wrCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".read1Data"}, read1Data, e.d1);
            chk({e.name, ".read2Data"}, read2Data, e.d2);
            chk({e.name, ".read1Uninit"}, {15'd0, read1Uninit}, {15'd0, e.u1});
            chk({e.name, ".read2Uninit"}, {15'd0, read2Uninit}, {15'd0, e.u2});
            chk({e.name, ".wrCount"}, wrCount, e.cnt);
        end
    end

    task automatic cyc(input logic rst, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] ws, input logic [15:0] wd, input logic we,
                       input logic [15:0] e1, input logic [15:0] e2,
                       input logic eu1, input logic eu2, input logic [15:0] ec, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; read1RegSel = r1; read2RegSel = r2;
        writeRegSel = ws; writeData = wd; writeEn = we;
        e.d1 = e1; e.d2 = e2; e.u1 = eu1; e.u2 = eu2; e.cnt = ec; e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        cyc(0, 2, 2, 2, 16'h1234, 1, 16'h0, 16'h0, 1, 1, 16'd0, "rst_byp_supp");
        cyc(0, 2, 2, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'd0, "rst_idle");
        for (int i = 0; i < 8; i++)
            cyc(1, i[2:0], 3'(7 - i), 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'd0, "reset_read");
        cyc(1, 3, 3, 3, 16'hBEEF, 1, 16'hBEEF, 16'hBEEF, 0, 0, 16'd0, "r3_bypass");
        cyc(1, 3, 3, 0, 16'h0, 0, 16'hBEEF, 16'hBEEF, 0, 0, 16'd1, "r3_stored");
        cyc(1, 0, 0, 5, 16'h1111, 1, 16'h0, 16'h0, 1, 1, 16'd1, "r5_load");
        cyc(1, 5, 4, 4, 16'h4444, 1, 16'h1111, 16'h4444, 0, 0, 16'd2, "r4_load");
        cyc(1, 5, 4, 5, 16'h2222, 1, 16'h2222, 16'h4444, 0, 0, 16'd3, "r5_bypass");
        cyc(1, 5, 5, 0, 16'h0, 0, 16'h2222, 16'h2222, 0, 0, 16'd4, "r5_stored");
        cyc(1, 7, 7, 7, 16'hA5A5, 1, 16'hA5A5, 16'hA5A5, 0, 0, 16'd4, "r7_first");
        cyc(1, 7, 6, 7, 16'h5A5A, 1, 16'h5A5A, 16'h0, 0, 1, 16'd5, "r7_second");
        cyc(1, 7, 7, 0, 16'h0, 0, 16'h5A5A, 16'h5A5A, 0, 0, 16'd6, "r7_last_wins");
        cyc(1, 1, 1, 1, 16'h0F0F, 1, 16'h0F0F, 16'h0F0F, 0, 0, 16'd6, "r1_load");
        cyc(1, 1, 3, 0, 16'h0, 0, 16'h0F0F, 16'hBEEF, 0, 0, 16'd7, "r1_stored");
        // rst_n falls 1 time unit after the edge, well before the negedge check
        cyc(0, 1, 3, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'd0, "async_rst");
        cyc(0, 1, 1, 1, 16'h7777, 1, 16'h0, 16'h0, 1, 1, 16'd0, "rst_write");
        cyc(1, 1, 3, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'd0, "write_dropped");
        cyc(1, 7, 5, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'd0, "post_rst_clear");
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
            #1;
            writeEn = 1'b1; writeRegSel = i[2:0]; writeData = i[15:0];
        end
        cyc(1, 2, 2, 2, 16'hAAAA, 1, 16'hAAAA, 16'hAAAA, 0, 0, 16'hFFFE, "sat_fffe");
        cyc(1, 2, 3, 3, 16'hBBBB, 1, 16'hAAAA, 16'hBBBB, 0, 0, 16'hFFFF, "sat_reach");
        cyc(1, 2, 3, 2, 16'hCCCC, 1, 16'hCCCC, 16'hBBBB, 0, 0, 16'hFFFF, "sat_hold");
        cyc(1, 2, 3, 0, 16'h0, 0, 16'hCCCC, 16'hBBBB, 0, 0, 16'hFFFF, "sat_regs");
        cyc(1, 5, 4, 0, 16'h0, 0, 16'hFFFD, 16'hFFFC, 0, 0, 16'hFFFF, "bulk_regs");
        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
